// File: rtl/eu_fetch_pkg.sv
// eu_fetch_pkg: shared types and constants for the execution-unit parameter
// fetcher.
//   fetch_state_e  : fetcher FSM states
//   bytes_per_beat : byte stride of one SDRAM read beat
//   ADD_*          : adder parameter field positions inside beat 0
package eu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } fetch_state_e;

  function automatic int bytes_per_beat(input int data_w);
    return data_w / 8;
  endfunction

  // Adder parameter layout (beat 0): s_a[15:0], s_b[31:16], z_tot[39:32]
  localparam int ADD_SA_LSB   = 0;
  localparam int ADD_SA_W     = 16;
  localparam int ADD_SB_LSB   = 16;
  localparam int ADD_SB_W     = 16;
  localparam int ADD_ZTOT_LSB = 32;
  localparam int ADD_ZTOT_W   = 8;

endpackage

// File: rtl/eu_param_fetch_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Grants the lowest requesting
// index at or after ptr, wrapping past NUM_EU-1 back to 0.
//   req : request vector
//   ptr : first index to consider
//   gnt : one-hot grant
//   idx : binary index of the grant
//   any : at least one request present
module rr_arbiter #(
  parameter int NUM_EU = 4
) (
  input  logic [NUM_EU-1:0]         req,
  input  logic [$clog2(NUM_EU)-1:0] ptr,
  output logic [NUM_EU-1:0]         gnt,
  output logic [$clog2(NUM_EU)-1:0] idx,
  output logic                      any
);
  localparam int IW = $clog2(NUM_EU);

  logic [IW:0] s;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = '0;
    for (int k = 0; k < NUM_EU; k++) begin
      // one extra bit so ptr+k can be wrapped for non-power-of-two NUM_EU
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(NUM_EU)) s = s - (IW+1)'(NUM_EU);
      if (!any && req[s[IW-1:0]]) begin
        any            = 1'b1;
        gnt[s[IW-1:0]] = 1'b1;
        idx            = s[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/eu_param_fetch.sv
// eu_param_fetch: one SDRAM read port shared by NUM_EU execution units.
// Each EU pulses fetch_req with a base address and beat count; requests are
// served round-robin, one SDRAM beat in flight at a time, and the assembled
// word is broadcast on param_data with a one-hot param_valid strobe.
//   clk, rst          : clock, asynchronous active-high reset
//   fetch_req/addr/len: per-EU request pulse with sampled address/length
//   sdram_req/addr    : read request, held until sdram_gnt
//   sdram_gnt         : request accepted
//   sdram_rvalid/rdata: read return
//   param_data        : assembled beats, beat k at [k*SDRAM_DATA_W +: SDRAM_DATA_W]
//   param_valid       : one-hot completion strobe
//   busy              : per-EU pending or in flight
//   err_overrun       : sticky, request dropped because the EU was busy
module eu_param_fetch
  import eu_fetch_pkg::*;
#(
  parameter int NUM_EU       = 4,
  parameter int SDRAM_DATA_W = 128,
  parameter int ADDR_W       = 32,
  parameter int MAX_BEATS    = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_EU-1:0]                       fetch_req,
  input  logic [NUM_EU*ADDR_W-1:0]                fetch_addr,
  input  logic [NUM_EU*$clog2(MAX_BEATS+1)-1:0]   fetch_len,
  output logic                                    sdram_req,
  output logic [ADDR_W-1:0]                       sdram_addr,
  input  logic                                    sdram_gnt,
  input  logic                                    sdram_rvalid,
  input  logic [SDRAM_DATA_W-1:0]                 sdram_rdata,
  output logic [MAX_BEATS*SDRAM_DATA_W-1:0]       param_data,
  output logic [NUM_EU-1:0]                       param_valid,
  output logic [NUM_EU-1:0]                       busy,
  output logic                                    err_overrun
);
  localparam int LEN_W  = $clog2(MAX_BEATS+1);
  localparam int IDX_W  = $clog2(NUM_EU);
  localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int BPB    = bytes_per_beat(SDRAM_DATA_W);

  fetch_state_e                             state;
  logic [IDX_W-1:0]                         idx, rr_ptr, arb_idx;
  logic [NUM_EU-1:0]                        idx_oh, arb_gnt;
  logic                                     arb_any;
  logic [BEAT_W-1:0]                        beat;
  logic [NUM_EU-1:0]                        pending, accept, overrun;
  logic [NUM_EU-1:0]                        done_oh, inflight_oh;
  logic [ADDR_W-1:0]                        addr_q [NUM_EU];
  logic [LEN_W-1:0]                         len_q  [NUM_EU];
  logic [MAX_BEATS-1:0][SDRAM_DATA_W-1:0]   data_q;
  logic                                     last_beat;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0) return LEN_W'(1);
    if (l > LEN_W'(MAX_BEATS)) return LEN_W'(MAX_BEATS);
    return l;
  endfunction

  rr_arbiter #(.NUM_EU(NUM_EU)) u_arb (
    .req (pending),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign inflight_oh = (state != IDLE) ? idx_oh : '0;
  assign done_oh     = (state == OUT)  ? idx_oh : '0;
  assign busy        = pending | inflight_oh;
  // The completing EU may post its next fetch in its own OUT cycle.
  assign accept      = fetch_req & (~busy | done_oh);
  assign overrun     = fetch_req & busy & ~done_oh;

  assign param_valid = done_oh;
  assign param_data  = data_q;
  assign sdram_req   = (state == REQ);
  assign sdram_addr  = sdram_req ? addr_q[idx] + ADDR_W'(beat) * ADDR_W'(BPB) : '0;
  assign last_beat   = (LEN_W'(beat) + LEN_W'(1)) == len_q[idx];

  // Request capture: set wins over the OUT-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      err_overrun <= 1'b0;
      for (int i = 0; i < NUM_EU; i++) begin
        addr_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      pending <= (pending & ~done_oh) | accept;
      if (|overrun) err_overrun <= 1'b1;
      for (int i = 0; i < NUM_EU; i++) begin
        if (accept[i]) begin
          addr_q[i] <= fetch_addr[i*ADDR_W +: ADDR_W];
          len_q[i]  <= clamp_len(fetch_len[i*LEN_W +: LEN_W]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      idx_oh <= '0;
      beat   <= '0;
      rr_ptr <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: if (arb_any) begin
          idx    <= arb_idx;
          idx_oh <= arb_gnt;
          beat   <= '0;
          data_q <= '0;   // unfetched slots read as zero
          state  <= REQ;
        end
        REQ: if (sdram_gnt) state <= WAIT;
        WAIT: if (sdram_rvalid) begin
          data_q[beat] <= sdram_rdata;
          if (last_beat) state <= OUT;
          else begin
            beat  <= beat + 1'b1;
            state <= REQ;
          end
        end
        OUT: begin
          rr_ptr <= (idx == IDX_W'(NUM_EU-1)) ? '0 : idx + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
